// File: rtl/key_debounce_multi_if.sv
// Key conditioner signal bundle: raw pins in, debounced level and event strobes out.
interface key_debounce_multi_if #(
    parameter int unsigned KEY_NUM = 4
);
    logic [KEY_NUM-1:0] key_in;
    logic [KEY_NUM-1:0] key_level;
    logic [KEY_NUM-1:0] key_press;
    logic [KEY_NUM-1:0] key_release;
    logic [KEY_NUM-1:0] key_long;
    logic [KEY_NUM-1:0] key_repeat;

    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long,
        input  key_repeat
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_long,
        output key_repeat
    );
endinterface

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner: 2-FF synchroniser, stability debounce,
// press/release strobes, long-press detection and auto-repeat per key.
module key_debounce_multi #(
    parameter int unsigned KEY_NUM      = 4,
    parameter int unsigned ACTIVE_LOW   = 1,
    parameter int unsigned DEBOUNCE_CYC = 999999,
    parameter int unsigned LONG_CYC     = 49999999,
    parameter int unsigned REPEAT_CYC   = 9999999,
    parameter int unsigned CNT_W        = 26
) (
    input  logic                 s_clk,
    input  logic                 s_rst_n,
    key_debounce_multi_if.slave  kif
);

    localparam logic             IDLE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] DEB_TC   = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] LONG_TC  = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_TC   = CNT_W'(REPEAT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_LONG
    } state_t;

    logic [KEY_NUM-1:0] sync1;
    logic [KEY_NUM-1:0] sync2;
    logic [KEY_NUM-1:0] p1;
    logic [KEY_NUM-1:0] p2;
    logic [KEY_NUM-1:0] level;
    logic [CNT_W-1:0]   dcnt [KEY_NUM];
    logic [KEY_NUM-1:0] dcnt_clr;
    logic [KEY_NUM-1:0] acc_press;
    logic [KEY_NUM-1:0] acc_release;

    state_t             state     [KEY_NUM];
    state_t             state_nxt [KEY_NUM];
    logic [CNT_W-1:0]   hcnt      [KEY_NUM];
    logic [CNT_W-1:0]   hcnt_nxt  [KEY_NUM];

    logic [KEY_NUM-1:0] press_q,   press_nxt;
    logic [KEY_NUM-1:0] release_q, release_nxt;
    logic [KEY_NUM-1:0] long_q,    long_nxt;
    logic [KEY_NUM-1:0] repeat_q,  repeat_nxt;

    // Pin polarity removed so that 1 always means pressed internally.
    assign p1 = sync1 ^ {KEY_NUM{IDLE_PIN}};
    assign p2 = sync2 ^ {KEY_NUM{IDLE_PIN}};

    // Debounce terminal count decides acceptance; the strobe FSM sees it one edge early so
    // its registered strobes land on the same edge as the new level.
    always_comb begin
        dcnt_clr    = '0;
        acc_press   = '0;
        acc_release = '0;
        for (int unsigned i = 0; i < KEY_NUM; i++) begin
            dcnt_clr[i] = (p1[i] != p2[i]) || (p2[i] == level[i]);
            if (!dcnt_clr[i] && (dcnt[i] == DEB_TC)) begin
                acc_press[i]   = p2[i];
                acc_release[i] = ~p2[i];
            end
        end
    end

    // Synchroniser, debounce counter and accepted level.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sync1 <= {KEY_NUM{IDLE_PIN}};
            sync2 <= {KEY_NUM{IDLE_PIN}};
            level <= '0;
            for (int unsigned i = 0; i < KEY_NUM; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync1 <= kif.key_in;
            sync2 <= sync1;
            for (int unsigned i = 0; i < KEY_NUM; i++) begin
                if (dcnt_clr[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_TC) begin
                    level[i] <= p2[i];
                    dcnt[i]  <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    // Hold FSM next state and strobes; release wins over long/repeat terminal counts.
    always_comb begin
        press_nxt   = '0;
        release_nxt = '0;
        long_nxt    = '0;
        repeat_nxt  = '0;
        for (int unsigned i = 0; i < KEY_NUM; i++) begin
            state_nxt[i] = state[i];
            hcnt_nxt[i]  = hcnt[i];
            case (state[i])
                ST_IDLE: begin
                    if (acc_press[i]) begin
                        press_nxt[i] = 1'b1;
                        hcnt_nxt[i]  = '0;
                        state_nxt[i] = ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (acc_release[i]) begin
                        release_nxt[i] = 1'b1;
                        hcnt_nxt[i]    = '0;
                        state_nxt[i]   = ST_IDLE;
                    end else if (hcnt[i] == LONG_TC) begin
                        long_nxt[i]  = 1'b1;
                        hcnt_nxt[i]  = '0;
                        state_nxt[i] = ST_LONG;
                    end else begin
                        hcnt_nxt[i] = hcnt[i] + 1'b1;
                    end
                end
                ST_LONG: begin
                    if (acc_release[i]) begin
                        release_nxt[i] = 1'b1;
                        hcnt_nxt[i]    = '0;
                        state_nxt[i]   = ST_IDLE;
                    end else if (REPEAT_CYC != 0) begin
                        if (hcnt[i] == REP_TC) begin
                            repeat_nxt[i] = 1'b1;
                            hcnt_nxt[i]   = '0;
                        end else begin
                            hcnt_nxt[i] = hcnt[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt[i] = ST_IDLE;
                    hcnt_nxt[i]  = '0;
                end
            endcase
        end
    end

    // FSM state, hold counter and registered strobes.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            for (int unsigned i = 0; i < KEY_NUM; i++) begin
                state[i] <= ST_IDLE;
                hcnt[i]  <= '0;
            end
        end else begin
            press_q   <= press_nxt;
            release_q <= release_nxt;
            long_q    <= long_nxt;
            repeat_q  <= repeat_nxt;
            for (int unsigned i = 0; i < KEY_NUM; i++) begin
                state[i] <= state_nxt[i];
                hcnt[i]  <= hcnt_nxt[i];
            end
        end
    end

    assign kif.key_level   = level;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_long    = long_q;
    assign kif.key_repeat  = repeat_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with DEBOUNCE_CYC=9, LONG_CYC=50, REPEAT_CYC=20
// (plus a REPEAT_CYC=0 instance). Edge 0 is the first rising edge after a pin change.
module tb_key_debounce_multi;

    localparam int unsigned KN = 4;

    logic s_clk   = 1'b0;
    logic s_rst_n = 1'b0;

    key_debounce_multi_if #(.KEY_NUM(KN)) kif ();
    key_debounce_multi_if #(.KEY_NUM(KN)) kif_nr ();

    key_debounce_multi #(
        .KEY_NUM(KN), .ACTIVE_LOW(1), .DEBOUNCE_CYC(9),
        .LONG_CYC(50), .REPEAT_CYC(20), .CNT_W(26)
    ) u_dut (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .kif(kif.slave)
    );

    key_debounce_multi #(
        .KEY_NUM(KN), .ACTIVE_LOW(1), .DEBOUNCE_CYC(9),
        .LONG_CYC(50), .REPEAT_CYC(0), .CNT_W(26)
    ) u_dut_nr (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .kif(kif_nr.slave)
    );

    always #5 s_clk = ~s_clk;

    int n_cmp = 0;
    int n_err = 0;

    int c_press [KN] = '{default: 0};
    int c_rel   [KN] = '{default: 0};
    int c_long  [KN] = '{default: 0};
    int c_rep   [KN] = '{default: 0};
    int nr_long [KN] = '{default: 0};
    int nr_rep  [KN] = '{default: 0};

    // Strobe tallies sampled on the falling edge.
    always @(negedge s_clk) begin
        for (int i = 0; i < int'(KN); i++) begin
            c_press[i] += int'(kif.key_press[i]);
            c_rel[i]   += int'(kif.key_release[i]);
            c_long[i]  += int'(kif.key_long[i]);
            c_rep[i]   += int'(kif.key_repeat[i]);
            nr_long[i] += int'(kif_nr.key_long[i]);
            nr_rep[i]  += int'(kif_nr.key_repeat[i]);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge s_clk);
            #1;
        end
    endtask

    int b0, b1, b2;

    initial begin
        kif.key_in    = '1;
        kif_nr.key_in = '1;
        s_rst_n       = 1'b0;
        tick(3);
        check_val("rst level",   kif.key_level,   4'h0);
        check_val("rst press",   kif.key_press,   4'h0);
        check_val("rst release", kif.key_release, 4'h0);
        check_val("rst long",    kif.key_long,    4'h0);
        check_val("rst repeat",  kif.key_repeat,  4'h0);
        s_rst_n = 1'b1;
        tick(2);

        // Clean press and release on key 0.
        kif.key_in[0] = 1'b0;
        tick(11);
        check_val("t1 press e10", kif.key_press, 4'h0);
        check_val("t1 level e10", kif.key_level, 4'h0);
        tick(1);
        check_val("t1 press e11", kif.key_press, 4'h1);
        check_val("t1 level e11", kif.key_level, 4'h1);
        tick(1);
        check_val("t1 press e12", kif.key_press, 4'h0);
        check_val("t1 level e12", kif.key_level, 4'h1);
        kif.key_in[0] = 1'b1;
        tick(11);
        check_val("t1 rel e10", kif.key_release, 4'h0);
        tick(1);
        check_val("t1 rel e11",  kif.key_release, 4'h1);
        check_val("t1 lvl rel",  kif.key_level,   4'h0);
        tick(1);
        check_val("t1 rel e12", kif.key_release, 4'h0);

        // Bounce on key 1: 4-cycle segments for 40 cycles, then settle low.
        b0 = c_press[1];
        b1 = c_rel[1];
        for (int i = 0; i < 10; i++) begin
            kif.key_in[1] = (i % 2 == 1);
            tick(4);
        end
        kif.key_in[1] = 1'b0;
        check_val("t2 no press", c_press[1] - b0, 0);
        check_val("t2 no rel",   c_rel[1] - b1, 0);
        check_val("t2 level",    kif.key_level, 4'h0);
        tick(11);
        check_val("t2 press e10", kif.key_press, 4'h0);
        tick(1);
        check_val("t2 press e11", kif.key_press, 4'h2);
        tick(1);
        kif.key_in[1] = 1'b1;
        tick(12);
        check_val("t2 release", kif.key_release, 4'h2);

        // Long press with repeat on key 2; release lands on the +150 repeat edge.
        b0 = c_rep[2];
        b1 = c_long[2];
        b2 = c_rel[2];
        kif.key_in[2] = 1'b0;
        tick(12);
        check_val("t3 press", kif.key_press, 4'h4);
        tick(49);
        check_val("t3 long +49", kif.key_long, 4'h0);
        tick(1);
        check_val("t3 long +50", kif.key_long, 4'h4);
        tick(19);
        check_val("t3 rep +69", kif.key_repeat, 4'h0);
        tick(1);
        check_val("t3 rep +70", kif.key_repeat, 4'h4);
        for (int k = 0; k < 3; k++) begin
            tick(20);
            check_val("t3 rep +90..130", kif.key_repeat, 4'h4);
        end
        tick(8);
        kif.key_in[2] = 1'b1;
        tick(11);
        check_val("t3 rel +149", kif.key_release, 4'h0);
        check_val("t3 rep +149", kif.key_repeat,  4'h0);
        tick(1);
        check_val("t3 rel +150", kif.key_release, 4'h4);
        check_val("t3 rep +150", kif.key_repeat,  4'h0);
        tick(30);
        check_val("t3 rep count",  c_rep[2] - b0,  4);
        check_val("t3 long count", c_long[2] - b1, 1);
        check_val("t3 rel count",  c_rel[2] - b2,  1);
        check_val("t3 level",      kif.key_level,  4'h0);

        // Short press on key 3.
        b0 = c_long[3];
        b1 = c_rel[3];
        kif.key_in[3] = 1'b0;
        tick(12);
        check_val("t4 press", kif.key_press, 4'h8);
        tick(29);
        kif.key_in[3] = 1'b1;
        tick(11);
        check_val("t4 rel e10", kif.key_release, 4'h0);
        tick(1);
        check_val("t4 rel e11", kif.key_release, 4'h8);
        tick(40);
        check_val("t4 no long", c_long[3] - b0, 0);
        check_val("t4 rel cnt", c_rel[3] - b1,  1);

        // Key 3 held on the repeat-disabled instance.
        b0 = nr_long[3];
        b1 = nr_rep[3];
        kif_nr.key_in[3] = 1'b0;
        tick(12);
        check_val("t4n press", kif_nr.key_press, 4'h8);
        tick(49);
        check_val("t4n long +49", kif_nr.key_long, 4'h0);
        tick(1);
        check_val("t4n long +50", kif_nr.key_long, 4'h8);
        tick(150);
        check_val("t4n long cnt", nr_long[3] - b0, 1);
        check_val("t4n rep cnt",  nr_rep[3] - b1,  0);
        kif_nr.key_in[3] = 1'b1;
        tick(12);
        check_val("t4n release", kif_nr.key_release, 4'h8);

        // Release acceptance on the long terminal-count edge of key 0.
        b0 = c_long[0];
        kif.key_in[0] = 1'b0;
        tick(12);
        check_val("t5 press", kif.key_press, 4'h1);
        tick(38);
        kif.key_in[0] = 1'b1;
        tick(11);
        check_val("t5 rel +49",  kif.key_release, 4'h0);
        check_val("t5 long +49", kif.key_long,    4'h0);
        tick(1);
        check_val("t5 rel +50",  kif.key_release, 4'h1);
        check_val("t5 long +50", kif.key_long,    4'h0);
        tick(20);
        check_val("t5 long cnt", c_long[0] - b0, 0);
        check_val("t5 level",    kif.key_level,  4'h0);

        // Reset while key 0 is held (asserted as the press strobe is high).
        b0 = c_rel[0];
        kif.key_in[0] = 1'b0;
        tick(12);
        check_val("t6 press", kif.key_press, 4'h1);
        s_rst_n = 1'b0;
        #1;
        check_val("t6 async press", kif.key_press, 4'h0);
        check_val("t6 async level", kif.key_level, 4'h0);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check_val("t6 in reset",
                      {12'h0, kif.key_level, kif.key_press, kif.key_release,
                       kif.key_long, kif.key_repeat}, 32'h0);
        end
        s_rst_n = 1'b1;
        tick(11);
        check_val("t6 press e10", kif.key_press, 4'h0);
        tick(1);
        check_val("t6 press e11", kif.key_press, 4'h1);
        check_val("t6 level e11", kif.key_level, 4'h1);
        tick(20);
        check_val("t6 no release", c_rel[0] - b0, 0);
        kif.key_in[0] = 1'b1;
        tick(12);
        check_val("t6 final release", kif.key_release, 4'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
